// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC frame/bitslip alignment path.
// SLIP_CNT_W is also used by the lane ISERDES wrappers that consume the
// slip position.
package adc_align_pkg;

  localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;
  localparam int         SLIP_CNT_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  // Slip position never wraps: it saturates at all-ones.
  function automatic logic [SLIP_CNT_W-1:0] slip_sat_inc(input logic [SLIP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adc_frame_align_ctrl.sv
// Frame alignment sequencer on the divided ADC clock. It compares the frame
// ISERDES word with FRAME_PATTERN and slips until the two match. Lock is
// declared after LOCK_COUNT consecutive matches, and lock is lost after
// LOSS_COUNT consecutive mismatches.
// Optional build macro: ADC_ALIGN_AUTO_RELOCK_EN. When it is defined, a
// loss of lock restarts alignment automatically. When it is not defined,
// a loss of lock parks the controller in FAIL.
module adc_frame_align_ctrl
  import adc_align_pkg::*;
#(
  parameter logic [7:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
  parameter int         WAIT_CYCLES   = 4,
  parameter int         LOCK_COUNT    = 16,
  parameter int         MAX_SLIPS     = 8,
  parameter int         LOSS_COUNT    = 4
) (
  input  logic                  clk_div,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  realign,
  input  logic [7:0]            frame_word,
  output logic                  bitslip,
  output logic [SLIP_CNT_W-1:0] bitslip_count,
  output logic                  locked,
  output logic                  data_valid,
  output logic                  align_err
);

  localparam int WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [MATCH_W-1:0]    LOCK_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]     MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
  localparam logic [SLIP_CNT_W-1:0] SLIP_LIMIT = SLIP_CNT_W'(MAX_SLIPS);

  align_state_t           state, state_nx;
  logic [WAIT_W-1:0]      wait_cnt, wait_nx;
  logic [MATCH_W-1:0]     match_cnt, match_nx;
  logic [MISS_W-1:0]      miss_cnt, miss_nx;
  logic [SLIP_CNT_W-1:0]  slip_nx;
  logic                   bitslip_nx, locked_nx, err_nx;
  logic                   hit, at_max;

  assign hit    = (frame_word == FRAME_PATTERN);
  assign at_max = (bitslip_count == SLIP_LIMIT);

  // State, counters and all outputs are registered together, so each
  // output changes on the same edge as the state transition that causes it.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
      bitslip_count <= '0;
      bitslip       <= 1'b0;
      locked        <= 1'b0;
      data_valid    <= 1'b0;
      align_err     <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_nx;
      match_cnt     <= match_nx;
      miss_cnt      <= miss_nx;
      bitslip_count <= slip_nx;
      bitslip       <= bitslip_nx;
      locked        <= locked_nx;
      data_valid    <= locked_nx;
      align_err     <= err_nx;
    end
  end

  // Next-state, counter and output decode. ena low beats realign.
  always_comb begin
    state_nx   = state;
    wait_nx    = wait_cnt;
    match_nx   = match_cnt;
    miss_nx    = miss_cnt;
    slip_nx    = bitslip_count;
    bitslip_nx = 1'b0;
    locked_nx  = locked;
    err_nx     = align_err;

    if (state != ST_IDLE && !ena) begin
      state_nx  = ST_IDLE;
      wait_nx   = '0;
      match_nx  = '0;
      miss_nx   = '0;
      slip_nx   = '0;
      locked_nx = 1'b0;
      err_nx    = 1'b0;
    end else if (state != ST_IDLE && realign) begin
      state_nx  = ST_WAIT;
      wait_nx   = '0;
      match_nx  = '0;
      miss_nx   = '0;
      slip_nx   = '0;
      locked_nx = 1'b0;
      err_nx    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_nx   = '0;
          match_nx  = '0;
          miss_nx   = '0;
          slip_nx   = '0;
          locked_nx = 1'b0;
          err_nx    = 1'b0;
          if (ena) state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state_nx = ST_CHECK;
          else                       wait_nx  = wait_cnt + 1'b1;
        end
        ST_CHECK: begin
          if (hit) begin
            match_nx = MATCH_W'(1);
            miss_nx  = '0;
            // A lock count of one is already satisfied by this first match.
            if (LOCK_COUNT == 1) begin
              state_nx  = ST_LOCKED;
              locked_nx = 1'b1;
            end else begin
              state_nx = ST_VERIFY;
            end
          end else if (at_max) begin
            state_nx = ST_FAIL;
            err_nx   = 1'b1;
          end else begin
            state_nx   = ST_SLIP;
            bitslip_nx = 1'b1;
            slip_nx    = slip_sat_inc(bitslip_count);
          end
        end
        ST_SLIP: begin
          state_nx = ST_WAIT;
          wait_nx  = '0;
        end
        ST_VERIFY: begin
          if (hit) begin
            if (match_cnt == LOCK_LAST) begin
              state_nx  = ST_LOCKED;
              locked_nx = 1'b1;
              miss_nx   = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else if (at_max) begin
            state_nx = ST_FAIL;
            err_nx   = 1'b1;
          end else begin
            state_nx   = ST_SLIP;
            bitslip_nx = 1'b1;
            slip_nx    = slip_sat_inc(bitslip_count);
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            miss_nx = '0;
          end else if (miss_cnt == MISS_LAST) begin
            locked_nx = 1'b0;
`ifdef ADC_ALIGN_AUTO_RELOCK_EN
            state_nx = ST_WAIT;
            wait_nx  = '0;
            match_nx = '0;
            miss_nx  = '0;
            slip_nx  = '0;
`else
            state_nx = ST_FAIL;
            err_nx   = 1'b1;
`endif
          end else begin
            miss_nx = miss_cnt + 1'b1;
          end
        end
        ST_FAIL: begin
          err_nx = 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Self-checking bench for adc_frame_align_ctrl. The input model is a frame
// word that rotates left by one bit on each bitslip pulse. Expected results
// are either hand-derived table entries or values computed from the
// rotation rules by simple arithmetic.
module tb_adc_frame_align_ctrl;

  localparam int W    = 4;
  localparam int L    = 16;
  localparam int MAXS = 8;
  localparam int LOSS = 4;

  logic       clk_div = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b0;
  logic       realign = 1'b0;
  logic [7:0] frame_word = 8'h00;
  logic       bitslip;
  logic [3:0] bitslip_count;
  logic       locked, data_valid, align_err;

  adc_frame_align_ctrl #(
    .FRAME_PATTERN(8'hF0), .WAIT_CYCLES(W), .LOCK_COUNT(L),
    .MAX_SLIPS(MAXS), .LOSS_COUNT(LOSS)
  ) dut (
    .clk_div(clk_div), .reset_n(reset_n), .ena(ena), .realign(realign),
    .frame_word(frame_word), .bitslip(bitslip), .bitslip_count(bitslip_count),
    .locked(locked), .data_valid(data_valid), .align_err(align_err)
  );

  always #5 clk_div = ~clk_div;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         slips = 0;
  bit         track = 1'b0;
  logic [7:0] base = 8'h00;

  typedef struct {
    logic [7:0] w;
    int         ep;
    bit         el;
    bit         ee;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
    int m;
    m = k % 8;
    return 8'((w << m) | (w >> (8 - m)));
  endfunction

  // Reference: the number of slips is the first rotation that yields the
  // pattern. If no rotation within the slip budget matches, alignment fails.
  task automatic model(input logic [7:0] w, output int p, output bit ok);
    p = MAXS;
    ok = 1'b0;
    for (int k = 0; k <= MAXS; k++) begin
      if (!ok && rotl(w, k) == 8'hF0) begin
        p = k;
        ok = 1'b1;
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    @(negedge clk_div);
    cyc++;
    if (track && bitslip === 1'b1) begin
      slips++;
      frame_word = rotl(base, slips);
    end
  endtask

  function automatic int outs();
    return int'({bitslip, bitslip_count, locked, data_valid, align_err});
  endfunction

  // Parks in IDLE and then raises ena. The next tick lands in cycle 1.
  task automatic start(input logic [7:0] w);
    ena = 1'b0;
    realign = 1'b0;
    tick();
    tick();
    base = w;
    slips = 0;
    frame_word = w;
    track = 1'b1;
    ena = 1'b1;
    cyc = 0;
  endtask

  task automatic run_trial(input string nm, input logic [7:0] w, input int ep,
                           input bit el, input bit ee);
    int pulses = 0, bad_pulse = 0, lock_cyc = -1, err_cyc = -1, dv_bad = 0;
    start(w);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bitslip === 1'b1) begin
        if (cyc != (W + 2) * (pulses + 1)) bad_pulse++;
        pulses++;
      end
      if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
      if (align_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (data_valid !== locked) dv_bad++;
    end
    check({nm, ".pulses"}, pulses, ep);
    check({nm, ".pulse_spacing_errs"}, bad_pulse, 0);
    check({nm, ".bitslip_count"}, bitslip_count, ep);
    check({nm, ".locked"}, locked, el);
    check({nm, ".align_err"}, align_err, ee);
    check({nm, ".lock_cycle"}, lock_cyc, el ? (W + 1 + ep * (W + 2) + L) : -1);
    check({nm, ".err_cycle"}, err_cyc, ee ? (W + 1 + MAXS * (W + 2) + 1) : -1);
    check({nm, ".dv_ne_locked"}, dv_bad, 0);
  endtask

  initial begin
    int p, pc;
    bit ok;
    logic [7:0] w;

    tbl[0] = '{8'hF0, 0, 1'b1, 1'b0};
    tbl[1] = '{8'h1E, 3, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8, 1'b0, 1'b1};
    tbl[3] = '{8'h78, 1, 1'b1, 1'b0};
    tbl[4] = '{8'hE1, 7, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8, 1'b0, 1'b1};

    // Reset state
    #1;
    check("reset_outs", outs(), 0);
    repeat (3) @(negedge clk_div);
    check("reset_outs_held", outs(), 0);
    reset_n = 1'b1;

    foreach (tbl[i]) run_trial($sformatf("tbl%0d", i), tbl[i].w, tbl[i].ep, tbl[i].el, tbl[i].ee);

    for (int i = 0; i < 8; i++) begin
      w = ($urandom_range(0, 1) == 0) ? rotl(8'hF0, $urandom_range(0, 7)) : 8'($urandom);
      model(w, p, ok);
      run_trial($sformatf("rnd%0d_%02h", i, w), w, p, ok, !ok);
    end

    // Loss qualification in LOCKED
    start(8'hF0);
    repeat (21) tick();
    check("loss.locked_at_21", locked, 1);
    track = 1'b0;
    frame_word = 8'h00;
    repeat (3) tick();
    frame_word = 8'hF0;
    tick();
    check("loss.three_miss_keeps_lock", locked, 1);
    frame_word = 8'h00;
    repeat (3) tick();
    check("loss.after_3rd_miss", locked, 1);
    tick();
    check("loss.locked_drops", locked, 0);
    check("loss.dv_drops", data_valid, 0);
`ifdef ADC_ALIGN_AUTO_RELOCK_EN
    check("loss.relock_no_err", align_err, 0);
    check("loss.relock_count_clr", bitslip_count, 0);
    repeat (4) tick();
    check("loss.relock_check_no_pulse", bitslip, 0);
    tick();
    check("loss.relock_pulse", bitslip, 1);
    check("loss.relock_count", bitslip_count, 1);
`else
    check("loss.align_err", align_err, 1);
    repeat (12) tick();
    check("loss.no_pulse_in_fail", bitslip_count, 0);
    check("loss.err_sticky", align_err, 1);
`endif

    // FAIL, then realign restarts from slip 0
    start(8'h00);
    repeat (60) tick();
    check("realign.err_before", align_err, 1);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("realign.err_cleared", align_err, 0);
    check("realign.count_cleared", bitslip_count, 0);
    repeat (4) tick();
    check("realign.no_pulse_c5", bitslip, 0);
    tick();
    check("realign.pulse_c6", bitslip, 1);
    check("realign.count_c6", bitslip_count, 1);

    // ena low during VERIFY
    start(8'h78);
    repeat (14) tick();
    check("ena_drop.count_before", bitslip_count, 1);
    ena = 1'b0;
    tick();
    check("ena_drop.outs_zero", outs(), 0);

    // ena low and realign together: IDLE wins, which shows up in pulse timing
    start(8'hF0);
    repeat (25) tick();
    check("prio.locked_before", locked, 1);
    track = 1'b0;
    frame_word = 8'h00;
    ena = 1'b0;
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("prio.outs_zero", outs(), 0);
    ena = 1'b1;
    cyc = 0;
    pc = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bitslip === 1'b1 && pc < 0) pc = cyc;
    end
    check("prio.first_pulse_cycle", pc, W + 2);

    // Reset asserted during a SLIP cycle
    start(8'h00);
    repeat (6) tick();
    check("rst_slip.pulse_before", bitslip, 1);
    reset_n = 1'b0;
    #1;
    check("rst_slip.outs_zero", outs(), 0);
    repeat (2) @(negedge clk_div);
    check("rst_slip.still_zero", outs(), 0);
    reset_n = 1'b1;
    slips = 0;
    frame_word = 8'h00;
    cyc = 0;
    repeat (5) tick();
    check("rst_slip.no_pulse_c5", bitslip, 0);
    check("rst_slip.count_c5", bitslip_count, 0);
    tick();
    check("rst_slip.pulse_c6", bitslip, 1);
    check("rst_slip.count_c6", bitslip_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_frame_align_ctrl.md
# adc_frame_align_ctrl

Sequencing controller for the SYZYGY ADC frame/bitslip alignment path. Runs on the divided ADC clock and compares the 8-bit frame ISERDES word against the expected frame pattern. Issues spaced bitslip pulses until the word matches, then qualifies lock over a run of consecutive matches. Exports locked/valid status, the slip position that the data-lane ISERDES blocks consume, and a hard alignment error when no rotation matches.

## Interface
- FRAME_PATTERN, 8'hF0, expected frame word when aligned
- WAIT_CYCLES, 4, clk_div cycles between a bitslip and the next compare (min 4)
- LOCK_COUNT, 16, consecutive matches required to declare lock (1..255)
- MAX_SLIPS, 8, slips attempted before declaring failure (1..15)
- LOSS_COUNT, 4, consecutive mismatches in lock that declare loss (1..15)
- clk_div  in  1  divided ADC clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  level; high runs alignment, low returns to IDLE
- realign  in  1  single-cycle pulse; restarts alignment from slip 0
- frame_word  in  8  frame ISERDES parallel output, clk_div domain
- bitslip  out  1  one-cycle bitslip pulse to all lane ISERDES
- bitslip_count  out  4  slips issued since alignment start
- locked  out  1  alignment qualified
- data_valid  out  1  ADC data usable; equals locked, registered
- align_err  out  1  MAX_SLIPS exhausted without match; sticky until ena low or realign

## Operation
- States: IDLE, WAIT, CHECK, SLIP, VERIFY, LOCKED, FAIL.
- IDLE: all outputs 0 and counters clear. ena=1 → WAIT.
- WAIT: wait_cnt counts 0..WAIT_CYCLES-1, then → CHECK.
- CHECK: frame_word==FRAME_PATTERN → VERIFY with match_cnt=1.
  - Otherwise, bitslip_count==MAX_SLIPS → FAIL.
  - Otherwise → SLIP.
- SLIP: bitslip=1 for exactly this cycle, bitslip_count+1, → WAIT.
- VERIFY: each match increments match_cnt. When match_cnt reaches LOCK_COUNT → LOCKED. Any mismatch → SLIP, or FAIL if bitslip_count==MAX_SLIPS.
- LOCKED: locked=data_valid=1.
  - miss_cnt counts consecutive mismatches; any match clears it.
  - miss_cnt==LOSS_COUNT → loss; behaviour set by Configuration.
- FAIL: align_err=1, no further bitslip pulses.
- From any non-IDLE state:
  - ena=0 → IDLE next cycle. ena has priority over realign.
  - realign=1 → WAIT with bitslip_count, match_cnt and miss_cnt cleared, and locked/align_err dropped.
- bitslip_count saturates at 15 and never wraps. Counters are sized to their parameters.

## Timing
- All outputs registered. Reset value of every output is 0; reset is asynchronous on reset_n fall, released synchronously by the surrounding reset bridge.
- ena sampled high at cycle 0: WAIT occupies cycles 1..WAIT_CYCLES, CHECK is cycle WAIT_CYCLES+1.
- Successive bitslip pulses are exactly WAIT_CYCLES+2 cycles apart (SLIP, WAIT×WAIT_CYCLES, CHECK).
- locked/data_valid rise on the edge after the LOCK_COUNT-th match. With defaults and an aligned input, they first read high at cycle 21.
- Loss: locked/data_valid drop on the edge after the LOSS_COUNT-th consecutive mismatch.
- reset_n low mid-operation (including during a bitslip pulse) forces the outputs to 0 immediately; no pulse is extended.

## Configuration
- ADC_ALIGN_AUTO_RELOCK_EN defined: loss of lock → WAIT with counters cleared, so realignment runs automatically.
- Not defined: loss of lock → FAIL with align_err=1, and the controller waits for realign or for ena to go low.

## Structure
- Shared package adc_align_pkg holds:
  - state enum type
  - default FRAME_PATTERN constant (8'hF0)
  - SLIP_CNT_W=4 width constant, shared with the lane ISERDES wrappers
- Single flat module with no sub-module. The wait, match and miss counters are small enough to stay inline.

## Test plan
- Aligned input (frame_word=8'hF0 constant), ena rises at cycle 0 → no bitslip, bitslip_count=0, locked and data_valid read 1 at cycle 21.
- Input rotated by 3 bits, re-rotating left one bit per bitslip pulse → exactly 3 pulses spaced 6 cycles apart, bitslip_count=3, locked asserts.
- Input constant 8'h00 → 8 pulses, then align_err=1, locked=0, no further pulses. A realign pulse restarts with bitslip_count=0.
- In LOCKED, inject 3 mismatches then 8'hF0 → locked stays 1. Inject 4 mismatches → locked drops. Auto-relock is macro-dependent: with the macro defined, the bench sees a new WAIT/CHECK cycle; without it, align_err=1.
- ena deasserted during VERIFY → IDLE next cycle, all outputs 0. ena and realign both high in the same cycle → IDLE wins.
- reset_n pulsed low during the SLIP cycle → bitslip falls immediately, all outputs 0. After release with ena=1, alignment restarts from bitslip_count=0.
